// File: rtl/rb_ctrl_pkg.sv
// rb_ctrl_pkg: opcodes, register-bank codes and sequencer state/class types
package rb_ctrl_pkg;
  localparam logic [3:0] OP_LOAD = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_NOP = 4'hF;
  localparam logic [5:0] WR_IDX = 6'd34;
  localparam logic [5:0] NOP_C = 6'd63;
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, LD_WAIT, ST_LATCH, ST_WAIT, RETIRE} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_NOP, CL_ILL} cls_t;
endpackage

// File: rtl/rb_decode.sv
// rb_decode: classifies an instruction and range-checks its register fields
module rb_decode
  import rb_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output cls_t        cls,
  output logic        regs_ok
);
  logic [3:0] op;
  assign op = instr[15:12];
  assign cls = !op[3] ? CL_ALU : op == OP_LOAD ? CL_LOAD : op == OP_STORE ? CL_STORE : op == OP_NOP ? CL_NOP : CL_ILL;
  assign regs_ok = instr[11:6] <= 6'd31 && instr[5:0] <= WR_IDX;
endmodule

// File: rtl/rb_sequencer.sv
// rb_sequencer: steps one instruction at a time through register-bank, ALU and memory control
module rb_sequencer
  import rb_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [1:0]  MC,
  output logic [4:0]  busA,
  output logic [5:0]  busB,
  output logic [5:0]  busC,
  output logic [2:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err_illegal,
  output logic        err_timeout
);
  state_t state, state_d;
  cls_t cls;
  logic [2:0] op;
  logic [5:0] rd, rs;
  logic [7:0] cnt, cnt_d;
  logic regs_ok, accept, illegal, tmo, alu_ph;

  rb_decode u_dec (.instr(instr), .cls(cls), .regs_ok(regs_ok));

  assign accept = instr_valid && instr_ready;
  assign illegal = cls == CL_ILL || (cls == CL_ALU && !regs_ok);
  // ack in the same cycle as the limit takes priority over the timeout
  assign tmo = (state == LD_WAIT || state == ST_WAIT) && !mem_ack && cnt == 8'(MEM_TIMEOUT - 1);

  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept)
          state_d = illegal ? RETIRE : cls == CL_ALU ? READ : cls == CL_LOAD ? LD_WAIT : cls == CL_STORE ? ST_LATCH : RETIRE;
      end
      READ: begin
        cnt_d = 8'(ALU_LAT - 1);
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
        state_d = cnt == 8'd0 ? WB : EXEC;
      end
      ST_LATCH: begin
        cnt_d = '0;
        state_d = ST_WAIT;
      end
      LD_WAIT, ST_WAIT: begin
        cnt_d = (mem_ack || tmo) ? 8'd0 : cnt + 8'd1;
        state_d = (mem_ack || tmo) ? RETIRE : state;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      rd <= '0;
      rs <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) op <= instr[14:12];
      if (accept) rd <= instr[11:6];
      if (accept) rs <= instr[5:0];
      if (accept && illegal) err_illegal <= 1'b1;
      if (tmo) err_timeout <= 1'b1;
    end
  end

  // the bank writes whenever MC is 00 and busC is a real register, so busC stays NOP_C outside WB
  assign alu_ph = state == READ || state == EXEC || state == WB;
  assign instr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == WB || state == RETIRE;
  assign MC = {state == LD_WAIT && mem_ack, state == ST_LATCH};
  assign busA = state == READ ? rd[4:0] : '0;
  assign busB = state == READ ? rs : '0;
  assign busC = state == WB ? rd : NOP_C;
  assign alu_op = alu_ph ? op : '0;
  assign mem_req = state == LD_WAIT || state == ST_WAIT;
  assign mem_we = state == ST_WAIT;
endmodule

// File: tb/tb_rb_sequencer.sv
// tb_rb_sequencer: directed vector table plus hand sequences for timeout, ack priority, abort and latency
`timescale 1ns/1ps
module tb_rb_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, instr_valid, mem_ack;
  logic [15:0] instr;
  logic instr_ready, mem_req, mem_we, busy, done, err_illegal, err_timeout;
  logic [1:0] MC;
  logic [4:0] busA;
  logic [5:0] busB, busC;
  logic [2:0] alu_op;
  logic [28:0] obs;

  logic v3, ack3, rdy3, rq3, we3, bz3, dn3, ei3, et3;
  logic [15:0] i3;
  logic [1:0] mc3;
  logic [4:0] ba3;
  logic [5:0] bb3, bc3;
  logic [2:0] ao3;

  int total = 0;
  int bad = 0;

  rb_sequencer #(.ALU_LAT(1), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .MC(MC), .busA(busA), .busB(busB), .busC(busC), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  rb_sequencer #(.ALU_LAT(3), .MEM_TIMEOUT(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v3), .instr(i3), .instr_ready(rdy3),
    .MC(mc3), .busA(ba3), .busB(bb3), .busC(bc3), .alu_op(ao3), .mem_req(rq3), .mem_we(we3),
    .mem_ack(ack3), .busy(bz3), .done(dn3), .err_illegal(ei3), .err_timeout(et3)
  );

  assign obs = {MC, busA, busB, busC, alu_op, mem_req, mem_we, done, instr_ready, busy, err_illegal, err_timeout};

  typedef struct {
    logic rn;
    logic v;
    logic [15:0] ins;
    logic ack;
    logic [28:0] exp;
  } vec_t;

  function automatic vec_t mk(logic rn, logic v, logic [15:0] ins, logic ack,
                              logic [1:0] mc, logic [4:0] ba, logic [5:0] bb, logic [5:0] bc, logic [2:0] ao,
                              logic rq, logic we, logic dn, logic rdy, logic bz, logic ei, logic et);
    vec_t r;
    r.rn = rn;
    r.v = v;
    r.ins = ins;
    r.ack = ack;
    r.exp = {mc, ba, bb, bc, ao, rq, we, dn, rdy, bz, ei, et};
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    int cyc, rq_cnt;
    logic seen, mc_hit, bc_hit, dn_hit, bc_other;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    mem_ack = 1'b0;
    v3 = 1'b0;
    i3 = '0;
    ack3 = 1'b0;
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 1, 16'h3083, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 2, 3, 63, 3, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 3, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 2, 3, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(mk(1, 1, 16'h9000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 1, 2, 0, 0, 63, 0, 1, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(mk(1, 1, 16'hA000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 0, 63, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 0, 63, 0, 1, 1, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(mk(1, 1, 16'hF000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(mk(1, 1, 16'hC000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 1, 0, 1, 1, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 1, 0));
    tv.push_back(mk(1, 1, 16'h17E2, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 31, 34, 63, 1, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 1, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 31, 1, 0, 0, 1, 0, 1, 0, 0));
    tv.push_back(mk(1, 1, 16'h0063, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 1, 0, 1, 1, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 1, 0));
    tv.push_back(mk(1, 1, 16'h0A01, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 1, 0, 1, 1, 0));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 63, 0, 0, 0, 0, 1, 0, 1, 0));

    foreach (tv[i]) begin
      @(negedge clk);
      rst_n = tv[i].rn;
      instr_valid = tv[i].v;
      instr = tv[i].ins;
      mem_ack = tv[i].ack;
      #1;
      check($sformatf("vec%0d", i), 32'(obs), 32'(tv[i].exp));
    end

    // load with no ack: times out after MEM_TIMEOUT request cycles
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr_valid = 1'b1;
    instr = 16'h9000;
    @(negedge clk);
    instr_valid = 1'b0;
    cyc = 0;
    rq_cnt = 0;
    seen = 1'b0;
    mc_hit = 1'b0;
    while (!seen && cyc < 30) begin
      #1;
      rq_cnt += int'(mem_req);
      mc_hit |= MC[1];
      seen = done;
      cyc++;
      if (!seen) @(negedge clk);
    end
    check("tmo_done_seen", 32'(seen), 1);
    check("tmo_req_cycles", rq_cnt, 8);
    check("tmo_no_mc_read", 32'(mc_hit), 0);
    check("tmo_flag", 32'(err_timeout), 1);
    check("tmo_illegal_clear", 32'(err_illegal), 0);
    @(negedge clk);
    #1;
    check("tmo_ready", 32'(instr_ready), 1);
    check("tmo_flag_sticky", 32'(err_timeout), 1);

    // ack in the final allowed cycle wins over the timeout
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr_valid = 1'b1;
    instr = 16'h9000;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (7) @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("ackwin_mc", 32'(MC), 2);
    check("ackwin_req", 32'(mem_req), 1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("ackwin_done", 32'(done), 1);
    check("ackwin_no_tmo", 32'(err_timeout), 0);

    // reset during EXEC must abort without writeback
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 16'h3083;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_exec_busc", 32'(busC), 63);
    bc_hit = 1'b0;
    dn_hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      bc_hit |= busC == 6'd2;
      dn_hit |= done;
    end
    check("abort_no_wb", 32'(bc_hit), 0);
    check("abort_no_done", 32'(dn_hit), 0);
    check("abort_ready", 32'(instr_ready), 1);

    // ALU_LAT=3: done and writeback 5 cycles after accept
    @(negedge clk);
    v3 = 1'b1;
    i3 = 16'h3083;
    @(negedge clk);
    v3 = 1'b0;
    cyc = 1;
    seen = 1'b0;
    bc_other = 1'b0;
    while (!seen && cyc < 20) begin
      #1;
      if (dn3) begin
        seen = 1'b1;
        check("lat3_busc", 32'(bc3), 2);
      end else begin
        bc_other |= bc3 != 6'd63;
        @(negedge clk);
        cyc++;
      end
    end
    check("lat3_seen", 32'(seen), 1);
    check("lat3_latency", cyc, 5);
    check("lat3_busc_quiet", 32'(bc_other), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rb_sequencer.md
Name: rb_sequencer

Overview:
- Micro-sequencer that drives the register bank's control inputs (MC, busA, busB, busC) one instruction at a time.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Steps each instruction through register read, ALU wait, writeback, or a memory load/store via the working register (index 34).
- Sits between the instruction source and the register bank, ALU and memory port.

Parameters:
- ALU_LAT, 1, cycles between operand presentation and dataC valid (1..15).
- MEM_TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..255).
- WR_IDX, 34, working-register index.
- NOP_C, 63, busC code meaning "no register write" (any value > WR_IDX).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  16  [15:12] opcode, [11:6] rd, [5:0] rs.
- instr_ready  out  1  sequencer can accept an instruction.
- MC  out  2  bit0 memory write (latch WR into WRdata), bit1 memory read (Mdata into WR).
- busA  out  5  register-bank A select.
- busB  out  6  register-bank B select.
- busC  out  6  register-bank write select.
- alu_op  out  3  ALU function, valid from READ through WB.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_ack  in  1  memory completes; on reads Mdata is valid in the same cycle.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse when an instruction retires.
- err_illegal  out  1  sticky: illegal opcode or out-of-range register.
- err_timeout  out  1  sticky: memory timeout.

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-low (rst_n).
- Reset values: state IDLE, MC=00, busA=0, busB=0, busC=NOP_C, alu_op=0, mem_req=0, mem_we=0, done=0, both error flags 0, counters 0. rst_n low mid-instruction aborts at the next edge; no partial writeback.
- Handshake: instr_ready=1 only in IDLE. An instruction is captured on the edge where instr_valid and instr_ready are both 1.
- busC rule: busC=NOP_C in every state except WB. This is required because the bank writes whenever MC=00 and busC <= WR_IDX.
- MC rule: MC is nonzero only in the cycles defined below.
- Opcode 0x0–0x7 (ALU):
  - Legal only if rd <= 31 and rs <= WR_IDX; otherwise illegal.
  - READ, 1 cycle: busA=rd[4:0], busB=rs, alu_op=opcode[2:0].
  - EXEC, ALU_LAT cycles via down-counter.
  - WB, 1 cycle: busC=rd, done=1.
  - Then IDLE. Latency from accept to done: 2+ALU_LAT cycles.
- Opcode 0x9 (LOAD):
  - LD_WAIT: mem_req=1, mem_we=0.
  - MC[1] is combinational: MC[1] = (state==LD_WAIT) & mem_ack. WR is therefore written exactly in the ack cycle.
  - On ack: done=1 next cycle, then IDLE.
- Opcode 0xA (STORE):
  - ST_LATCH, 1 cycle: MC=01.
  - ST_WAIT: mem_req=1, mem_we=1 until mem_ack.
  - Then done, then IDLE.
- Opcode 0xF (NOP): done pulse 1 cycle after accept.
- Other opcodes: set err_illegal, pulse done, no bank or memory activity. Error flags clear only on reset.
- Timeout:
  - Counter starts at 0 on entry to LD_WAIT or ST_WAIT and increments each cycle without ack.
  - When it reaches MEM_TIMEOUT: drop mem_req, set err_timeout, pulse done, return to IDLE. No MC pulse is issued.
  - If ack and the timeout compare occur in the same cycle, ack wins.
- Back-to-back: a new instruction may be accepted the cycle after done. The minimum issue interval is therefore latency+1.

Decomposition:
- Package rb_ctrl_pkg: opcode constants (OP_LOAD=4'h9, OP_STORE=4'hA, OP_NOP=4'hF), state enum (IDLE, READ, EXEC, WB, LD_WAIT, ST_LATCH, ST_WAIT, RETIRE), WR_IDX, NOP_C.
- Sub-module rb_decode: combinational decode of the captured instruction into class (alu/load/store/nop/illegal) and a register-range check.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> MC=00, busC=63, mem_req=0, instr_ready=1, both error flags 0.
- ALU instr=16'h3083 (op3, rd=2, rs=3), ALU_LAT=1 -> READ busA=2, busB=3, alu_op=3; busC=2 exactly 3 cycles after accept, with done in the same cycle; busC=63 in all other cycles.
- LOAD, mem_ack after 4 cycles -> mem_req high for 4 cycles, MC=10 only in the ack cycle, done the next cycle.
- STORE, immediate ack -> MC=01 for 1 cycle, then mem_req=1, mem_we=1; done after ack; MC=00 while mem_req is high.
- LOAD with no ack, MEM_TIMEOUT=8 -> mem_req drops after 8 cycles, err_timeout=1, MC never 10, instr_ready returns.
- Illegal cases: opcode 0xC -> err_illegal=1 and done, no bank activity. ALU with rd=40 -> same. rst_n pulse during EXEC -> busC never shows rd, state returns to IDLE.
